// File: rtl/mtimer_intr_gen.sv
// mtimer_intr_gen: memory-mapped 64-bit machine timer with prescaler, driving the core's level timer interrupt.
module mtimer_intr_gen #(
    parameter int          DW      = 32,
    parameter int          PRESC_W = 8,
    parameter logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_i,
    input  logic          we_i,
    input  logic [4:0]    addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o,
    output logic          ack_o,
    output logic          t_intr_o
);
    logic [63:0]        mtime, mtimecmp;
    logic               en;
    logic [PRESC_W-1:0] div, pcnt;
    logic [31:0]        hi_snap;
    logic [2:0]         sel;
    logic               wr, rd, tick, ge;
    logic [DW-1:0]      ctrl, rmux;
    logic               unused_addr;

    assign unused_addr = ^addr_i[1:0];

    always_comb begin
        sel  = addr_i[4:2];
        wr   = req_i & we_i;
        rd   = req_i & ~we_i;
        tick = en & (pcnt == div);
        ge   = mtime >= mtimecmp;
        ctrl = '0;
        ctrl[0] = en;
        ctrl[8 +: PRESC_W] = div;
        rmux = sel == 3'd0 ? mtime[31:0] :
               sel == 3'd1 ? hi_snap :
               sel == 3'd2 ? mtimecmp[31:0] :
               sel == 3'd3 ? mtimecmp[63:32] :
               sel == 3'd4 ? ctrl :
               sel == 3'd5 ? {{(DW-1){1'b0}}, ge} : '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mtime    <= '0;
            mtimecmp <= CMP_RST;
            en       <= 1'b0;
            div      <= '0;
            pcnt     <= '0;
            hi_snap  <= '0;
            rdata_o  <= '0;
            ack_o    <= 1'b0;
            t_intr_o <= 1'b0;
        end else begin
            ack_o    <= req_i;
            t_intr_o <= en & ge;
            if (rd) rdata_o <= rmux;
            // reading LO freezes the upper half so a following HI read is coherent
            if (rd && sel == 3'd0) hi_snap <= mtime[63:32];
            // a software write to either half beats a same-cycle tick
            if (wr && sel == 3'd0) mtime[31:0] <= wdata_i;
            else if (wr && sel == 3'd1) mtime[63:32] <= wdata_i;
            else if (tick) mtime <= mtime + 64'd1;
            if (wr && sel == 3'd2) mtimecmp[31:0] <= wdata_i;
            if (wr && sel == 3'd3) mtimecmp[63:32] <= wdata_i;
            if (wr && sel == 3'd4) begin
                en   <= wdata_i[0];
                div  <= wdata_i[8 +: PRESC_W];
                pcnt <= '0;
            end else begin
                pcnt <= (tick || !en) ? '0 : pcnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mtimer_intr_gen.sv
// tb_mtimer_intr_gen: directed scoreboard bench for the machine timer bus, prescaler and interrupt.
module tb_mtimer_intr_gen;
    logic        clk, rst, req, we, ack, t_intr;
    logic [4:0]  addr;
    logic [31:0] wdata, rdata;

    typedef struct packed {
        logic        chk;
        logic [31:0] lo;
        logic [31:0] hi;
    } exp_t;

    exp_t  sb[$];
    string tq[$];
    exp_t  e;
    string t;
    int    checks = 0;
    int    failures = 0;

    mtimer_intr_gen dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .rdata_o(rdata), .ack_o(ack), .t_intr_o(t_intr)
    );

    always #5 clk = ~clk;

    // every ack must match the oldest outstanding access, in order
    always @(negedge clk) begin
        if (!rst && ack) begin
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL spurious_ack got=%0d queued exp=nonzero", sb.size());
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                t = tq.pop_front();
                if (e.chk) begin
                    checks++;
                    assert (((rdata >= e.lo) && (rdata <= e.hi)) === 1'b1) else begin
                        failures++;
                        $error("FAIL %s got=%h exp=%h..%h", t, rdata, e.lo, e.hi);
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic acc(input bit w, input logic [4:0] a, input logic [31:0] d, input string tag,
                       input bit c, input logic [31:0] lo, input logic [31:0] hi);
        req = 1; we = w; addr = a; wdata = d;
        sb.push_back('{c, lo, hi});
        tq.push_back(tag);
        @(posedge clk); #1;
        req = 0; we = 0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        acc(1, a, d, "wr", 0, 0, 0);
    endtask

    task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] lo, input logic [31:0] hi);
        acc(0, a, 0, tag, 1, lo, hi);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain(input string tag);
        idle(1);
        chk(tag, sb.size(), 0);
    endtask

    initial begin
        clk = 0; rst = 1; req = 0; we = 0; addr = 0; wdata = 0;
        #3;
        chk("rst_ack", {31'b0, ack}, 0);
        chk("rst_intr", {31'b0, t_intr}, 0);
        chk("rst_rdata", rdata, 0);
        #9 rst = 0;
        @(posedge clk); #1;

        // async reset mid-access with interrupt active
        wr(5'h0C, 0); wr(5'h08, 0); wr(5'h10, 32'h1);
        rd(5'h14, "status_pre_rst", 1, 1);
        chk("pre_rst_intr", {31'b0, t_intr}, 1);
        chk("pre_rst_ack", {31'b0, ack}, 1);
        #2 rst = 1;
        #1;
        chk("async_rst_ack", {31'b0, ack}, 0);
        chk("async_rst_intr", {31'b0, t_intr}, 0);
        #3 rst = 0;
        sb.delete(); tq.delete();
        @(posedge clk); #1;
        rd(5'h08, "cmp_lo_rst", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd(5'h0C, "cmp_hi_rst", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd(5'h00, "mtime_lo_rst", 0, 0);
        rd(5'h10, "ctrl_rst", 0, 0);
        drain("drain_rst");

        // basic interrupt at mtime == 20
        wr(5'h0C, 0); wr(5'h08, 20); wr(5'h10, 32'h1);
        idle(20);
        chk("intr_at_20", {31'b0, t_intr}, 0);
        idle(1);
        chk("intr_after_20", {31'b0, t_intr}, 1);
        wr(5'h08, 100);
        chk("intr_cmp_write_cycle", {31'b0, t_intr}, 1);
        idle(1);
        chk("intr_cmp_raised", {31'b0, t_intr}, 0);
        drain("drain_basic");

        // prescaler div 3
        wr(5'h10, 0); wr(5'h04, 0); wr(5'h00, 0); wr(5'h10, 32'h0301);
        idle(40);
        rd(5'h00, "presc_40cyc", 9, 11);
        rd(5'h10, "ctrl_div3", 32'h0301, 32'h0301);
        drain("drain_presc");

        // carry across halves and snapshot coherence
        wr(5'h10, 0); wr(5'h04, 0); wr(5'h00, 32'hFFFF_FFFE); wr(5'h10, 32'h1);
        rd(5'h00, "carry_lo_pre", 32'hFFFF_FFFE, 32'hFFFF_FFFE);
        idle(1);
        rd(5'h04, "snap_hi_stale", 0, 0);
        rd(5'h00, "carry_lo", 0, 2);
        rd(5'h04, "carry_hi", 1, 1);

        // full 64-bit wrap
        wr(5'h10, 0); wr(5'h04, 32'hFFFF_FFFF); wr(5'h00, 32'hFFFF_FFFF); wr(5'h10, 32'h1);
        idle(1);
        rd(5'h00, "wrap_lo", 0, 2);
        rd(5'h04, "wrap_hi", 0, 0);

        // write vs tick collision, then back-to-back and reserved offsets
        wr(5'h00, 5);
        rd(5'h00, "collide_lo", 5, 5);
        rd(5'h04, "collide_hi", 0, 0);
        rd(5'h08, "b2b_rd1", 100, 100);
        acc(1, 5'h08, 32'h1234, "b2b_wr_hold", 1, 100, 100);
        rd(5'h08, "b2b_rd2", 32'h1234, 32'h1234);
        wr(5'h18, 32'hFFFF);
        rd(5'h18, "rsvd_18", 0, 0);
        rd(5'h1C, "rsvd_1c", 0, 0);

        // disable while interrupting
        wr(5'h08, 0);
        idle(1);
        chk("intr_cmp0", {31'b0, t_intr}, 1);
        wr(5'h10, 0);
        chk("intr_dis_cycle", {31'b0, t_intr}, 1);
        idle(1);
        chk("intr_disabled", {31'b0, t_intr}, 0);
        rd(5'h00, "frozen_1", 16, 16);
        rd(5'h14, "status_dis", 1, 1);
        idle(3);
        rd(5'h00, "frozen_2", 16, 16);
        rd(5'h10, "ctrl_off", 0, 0);
        drain("drain_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mtimer_intr_gen.md
Name: mtimer_intr_gen

Overview:
- Memory-mapped machine timer that drives the core's timer interrupt input `t_intr`. It is the producer end of that interrupt line.
- Holds a 64-bit free-running `mtime` counter, a 64-bit `mtimecmp` compare register and a programmable prescaler.
- Asserts a level interrupt while `mtime >= mtimecmp` and the timer is enabled.
- Sits on the data-memory-side peripheral bus next to `data_mem`; the core's address decoder provides `req_i`.

Parameters:
- DW, 32, bus data width; fixed at 32, the register map assumes 32-bit words.
- PRESC_W, 8, width of the prescaler divider field and counter.
- CMP_RST, 64'hFFFF_FFFF_FFFF_FFFF, reset value of `mtimecmp` (no interrupt after reset).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- req_i  in  1  bus request, valid for one cycle per access
- we_i  in  1  1 = write, 0 = read; qualified by `req_i`
- addr_i  in  5  byte offset; bits [4:2] select the register, bits [1:0] are ignored
- wdata_i  in  DW  write data
- rdata_o  out  DW  read data; valid when `ack_o` = 1
- ack_o  out  1  access acknowledge
- t_intr_o  out  1  machine timer interrupt to the core (`t_intr`)

Behaviour:
- Reset (async, `rst_i` = 1):
  - `mtime` = 0, `mtimecmp` = CMP_RST.
  - CTRL = 0 (disabled, div = 0), prescaler counter = 0, `hi_snap` = 0.
  - `rdata_o` = 0, `ack_o` = 0, `t_intr_o` = 0.
  - Reset mid-access drops the pending ack.
- Register map (offset, access, content):
  - 0x00 MTIME_LO, rw.
  - 0x04 MTIME_HI, rw. A read returns `hi_snap`, not live `mtime[63:32]`.
  - 0x08 MTIMECMP_LO, rw.
  - 0x0C MTIMECMP_HI, rw.
  - 0x10 CTRL, rw: bit0 = en, bits[8+PRESC_W-1:8] = div; all other bits read 0.
  - 0x14 STATUS, ro: bit0 = live compare result (`mtime >= mtimecmp`, regardless of en).
  - 0x18 and 0x1C: writes ignored, reads return 0, still acked.
- Bus timing:
  - Request sampled at posedge with `req_i` = 1.
  - `ack_o` = 1 for exactly the next cycle; `rdata_o` is registered and valid in that same cycle.
  - Back-to-back requests are accepted every cycle (throughput 1/cycle).
  - `rdata_o` holds its last value when no read is in progress; write acks also leave it unchanged.
- Atomic 64-bit read: a read of MTIME_LO returns `mtime[31:0]` and in the same cycle latches `mtime[63:32]` into `hi_snap`. Software reads LO, then HI.
- Prescaler:
  - With en = 1, `pcnt` increments each cycle.
  - When `pcnt == div`: `pcnt` <= 0 and `mtime` <= `mtime` + 1 (a tick). div = 0 gives a tick every cycle; div = N gives a tick every N+1 cycles.
  - With en = 0: `mtime` holds, `pcnt` is forced to 0.
  - Any write to CTRL clears `pcnt`.
- Wrap-around: `mtime` 64'hFFFF_FFFF_FFFF_FFFF + 1 -> 0, no flag.
- Collisions:
  - A write to MTIME_LO/HI in the same cycle as a tick: the write wins, the tick is lost, and only the written half changes.
  - The 64-bit increment carries across the halves.
- Interrupt:
  - `t_intr_o` is registered: `t_intr_o` <= en & (`mtime >= mtimecmp`), unsigned 64-bit compare on current register values.
  - Latency is 1 cycle after the condition changes, whether the change comes from a tick or a register write.
  - The output is a level signal: it deasserts only when software raises `mtimecmp`, lowers `mtime`, or clears en.
  - There is no internal pending latch; STATUS is informational only.

Test Plan:
- Reset: pulse `rst_i` asynchronously mid-cycle -> `t_intr_o` = 0, `ack_o` = 0 immediately. Then read 0x08/0x0C -> 0xFFFFFFFF/0xFFFFFFFF, and 0x00 -> 0.
- Basic interrupt:
  - Stimulus: write CMP_HI = 0, CMP_LO = 20, CTRL = 0x1 (en, div 0).
  - Required: `t_intr_o` rises exactly 1 cycle after `mtime` reaches 20.
  - Then write CMP_LO = 100 -> `t_intr_o` falls 1 cycle after the write lands.
- Prescaler: CTRL = 0x0301 (div 3) -> `mtime` increments once every 4 cycles. Over 40 cycles `mtime` advances by 10 (±1 at the start boundary).
- Atomic read and carry:
  - Stimulus: write MTIME_HI = 0, MTIME_LO = 0xFFFFFFFE, en, div 0.
  - Required: after the carry, a LO read returns 0x00000000–0x00000002 and the immediately following HI read returns 0x00000001, consistent with the snapshot.
  - Repeat with MTIME_HI = MTIME_LO = 0xFFFFFFFF -> wraps to 0.
- Collision/bus:
  - A write to MTIME_LO = 5 on a tick cycle -> the read returns 5, not 6.
  - Back-to-back read, write, read on consecutive cycles -> three consecutive `ack_o` pulses with correct data.
  - Read 0x1C -> 0, acked.
- Disable: with `t_intr_o` = 1, write CTRL = 0 -> `t_intr_o` = 0 the next cycle, `mtime` frozen, STATUS bit0 still 1.
